// File: rtl/uart_cmd_pkg.sv
// Shared state encodings and command width for the UART command sequencer.
package uart_cmd_pkg;
  localparam int CMD_W = 16;

  typedef enum logic {HIGH_WAIT = 1'b0, LOW_WAIT = 1'b1} rx_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_BUSY = 1'b1} tx_state_t;
endpackage

// File: rtl/uart_frame_timer.sv
// Loadable down-counter guarding the gap between the two bytes of a frame.
module uart_frame_timer #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [TW-1:0] count_q, count_d;

  // Saturates at zero so the zero flag stays stable until the next load.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = TW'(TIMEOUT_CYC);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/uart_cmd_sequencer.sv
// Assembles two received UART bytes into a command (high byte first) and
// sequences single-byte responses into the UART transmitter.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  output logic             rx_clr_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  output logic             frame_err,
  input  logic             send_resp,
  input  logic [7:0]       resp,
  output logic             trmt,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic             resp_sent
);
  rx_state_t        rx_state_q, rx_state_d;
  tx_state_t        tx_state_q, tx_state_d;
  logic [7:0]       high_q, high_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             trmt_q, trmt_d;
  logic             resp_sent_q, resp_sent_d;
  logic             tmr_load, tmr_dec, tmr_zero;

  uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  // A completing frame overrides a coincident acknowledge.
  always_comb begin
    rx_state_d  = rx_state_q;
    high_d      = high_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q & ~clr_cmd_rdy;
    frame_err_d = 1'b0;
    rx_clr_rdy  = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    case (rx_state_q)
      HIGH_WAIT: begin
        if (rx_rdy) begin
          high_d     = rx_data;
          rx_clr_rdy = 1'b1;
          tmr_load   = 1'b1;
          rx_state_d = LOW_WAIT;
        end
      end
      LOW_WAIT: begin
        if (rx_rdy) begin
          cmd_d       = {high_q, rx_data};
          cmd_rdy_d   = 1'b1;
          frame_err_d = cmd_rdy_q;
          rx_clr_rdy  = 1'b1;
          rx_state_d  = HIGH_WAIT;
        end else if (tmr_zero) begin
          frame_err_d = 1'b1;
          rx_state_d  = HIGH_WAIT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: rx_state_d = HIGH_WAIT;
    endcase
  end

  // tx_done may still be high from the previous byte during the trmt cycle.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_d  = resp;
          trmt_d     = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done && !trmt_q) begin
          resp_sent_d = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= HIGH_WAIT;
      tx_state_q  <= TX_IDLE;
      high_q      <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      high_q      <= high_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frame_err_q <= frame_err_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;
  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign resp_sent = resp_sent_q;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomized self-checking bench for uart_cmd_sequencer; a second instance with
// the default timeout covers long inter-byte gaps.
module tb_uart_cmd_sequencer;
  localparam int T = 100;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rx_rdy = 1'b0, clr_cmd_rdy = 1'b0, send_resp = 1'b0, tx_done = 1'b0;
  logic [7:0]  rx_data = '0, resp = '0;
  logic        rx_clr_rdy, cmd_rdy, frame_err, trmt, resp_sent;
  logic [15:0] cmd;
  logic [7:0]  tx_data;

  logic        rx_rdy_l = 1'b0, clr_cmd_rdy_l = 1'b0;
  logic [7:0]  rx_data_l = '0;
  logic        rx_clr_rdy_l, cmd_rdy_l, frame_err_l, trmt_l, resp_sent_l;
  logic [15:0] cmd_l;
  logic [7:0]  tx_data_l;

  int vectors = 0, miscompares = 0, cyc = 0;
  int clr_cnt = 0, ferr_cnt = 0, trmt_cnt = 0, sent_cnt = 0;
  int clr_cnt_l = 0, ferr_cnt_l = 0, txl_cnt = 0;

  logic [15:0] exp_cmd = '0;
  logic        exp_rdy = 1'b0;

  uart_cmd_sequencer #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_clr_rdy(rx_clr_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err),
    .send_resp(send_resp), .resp(resp), .trmt(trmt), .tx_data(tx_data),
    .tx_done(tx_done), .resp_sent(resp_sent)
  );

  uart_cmd_sequencer dut_long (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy_l), .rx_data(rx_data_l), .rx_clr_rdy(rx_clr_rdy_l),
    .cmd(cmd_l), .cmd_rdy(cmd_rdy_l), .clr_cmd_rdy(clr_cmd_rdy_l), .frame_err(frame_err_l),
    .send_resp(1'b0), .resp(8'h00), .trmt(trmt_l), .tx_data(tx_data_l),
    .tx_done(1'b0), .resp_sent(resp_sent_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_clr_rdy === 1'b1)   clr_cnt   <= clr_cnt + 1;
    if (frame_err === 1'b1)    ferr_cnt  <= ferr_cnt + 1;
    if (trmt === 1'b1)         trmt_cnt  <= trmt_cnt + 1;
    if (resp_sent === 1'b1)    sent_cnt  <= sent_cnt + 1;
    if (rx_clr_rdy_l === 1'b1) clr_cnt_l <= clr_cnt_l + 1;
    if (frame_err_l === 1'b1)  ferr_cnt_l <= ferr_cnt_l + 1;
    if (trmt_l === 1'b1 || resp_sent_l === 1'b1) txl_cnt <= txl_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Receiver model: holds rdy until rx_clr_rdy is seen, drops it at the next edge.
  task automatic send_byte(input bit lng, input logic [7:0] b, input logic clr);
    bit got;
    got = 1'b0;
    if (lng) begin rx_data_l = b; rx_rdy_l = 1'b1; clr_cmd_rdy_l = clr; end
    else     begin rx_data   = b; rx_rdy   = 1'b1; clr_cmd_rdy   = clr; end
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      got = lng ? (rx_clr_rdy_l === 1'b1) : (rx_clr_rdy === 1'b1);
      @(posedge clk);
      #1;
    end
    rx_rdy = 1'b0; rx_rdy_l = 1'b0; clr_cmd_rdy = 1'b0; clr_cmd_rdy_l = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL accept: byte %h, rx_clr_rdy not seen, required within 8 cycles", b);
    end
  endtask

  // clr_mode: 0 no acknowledge, 1 acknowledge before the frame, 2 acknowledge with completion.
  task automatic do_frame(input logic [7:0] hi, input logic [7:0] lo, input int gap, input int clr_mode);
    int c0, f0;
    logic prior;
    if (clr_mode == 1) begin
      clr_cmd_rdy = 1'b1; tick(1); clr_cmd_rdy = 1'b0;
      exp_rdy = 1'b0;
      vectors++;
      if (cmd_rdy !== 1'b0) begin
        miscompares++; $display("FAIL ack: cmd_rdy=%b required 0", cmd_rdy);
      end
    end
    c0 = clr_cnt; f0 = ferr_cnt; prior = exp_rdy;
    send_byte(1'b0, hi, 1'b0);
    tick(gap);
    if (gap <= T) begin
      send_byte(1'b0, lo, clr_mode == 2);
      exp_cmd = {hi, lo};
      exp_rdy = 1'b1;
    end
    vectors++;
    if (cmd !== exp_cmd || cmd_rdy !== exp_rdy) begin
      miscompares++;
      $display("FAIL frame: gap %0d cmd=%h cmd_rdy=%b required %h/%b", gap, cmd, cmd_rdy, exp_cmd, exp_rdy);
    end
    tick(1);
    vectors++;
    if (clr_cnt - c0 != ((gap <= T) ? 2 : 1)) begin
      miscompares++;
      $display("FAIL clr_pulses: gap %0d got %0d required %0d", gap, clr_cnt - c0, (gap <= T) ? 2 : 1);
    end
    if (!(clr_mode == 2 && prior)) begin
      vectors++;
      if (ferr_cnt - f0 != ((gap > T) ? 1 : int'(prior))) begin
        miscompares++;
        $display("FAIL frame_err_count: gap %0d got %0d required %0d", gap, ferr_cnt - f0,
                 (gap > T) ? 1 : int'(prior));
      end
    end
  endtask

  // Transmitter model: raises tx_done after dly cycles, clears it on trmt.
  task automatic tx_once(input logic [7:0] r, input int dly);
    int t0, s0;
    t0 = trmt_cnt; s0 = sent_cnt;
    resp = r; send_resp = 1'b1; tick(1); send_resp = 1'b0; resp = 8'($urandom);
    vectors++;
    if (trmt !== 1'b1 || tx_data !== r) begin
      miscompares++; $display("FAIL trmt: trmt=%b tx_data=%h required 1/%h", trmt, tx_data, r);
    end
    tick(1); tx_done = 1'b0;
    vectors++;
    if (trmt !== 1'b0 || resp_sent !== 1'b0) begin
      miscompares++; $display("FAIL trmt_pulse: trmt=%b resp_sent=%b required 0/0", trmt, resp_sent);
    end
    send_resp = 1'b1; tick(1); send_resp = 1'b0;
    tick(dly);
    vectors++;
    if (trmt_cnt - t0 != 1 || tx_data !== r || resp_sent !== 1'b0) begin
      miscompares++;
      $display("FAIL busy: trmt pulses %0d tx_data=%h resp_sent=%b required 1/%h/0",
               trmt_cnt - t0, tx_data, resp_sent, r);
    end
    tx_done = 1'b1; tick(1);
    vectors++;
    if (resp_sent !== 1'b1) begin
      miscompares++; $display("FAIL resp_sent: got %b required 1", resp_sent);
    end
    tick(1);
    vectors++;
    if (resp_sent !== 1'b0 || sent_cnt - s0 != 1) begin
      miscompares++; $display("FAIL resp_pulse: resp_sent=%b pulses %0d required 0/1", resp_sent, sent_cnt - s0);
    end
  endtask

  task automatic test_reset();
    tick(3);
    vectors++;
    if ({rx_clr_rdy, cmd, cmd_rdy, frame_err, trmt, tx_data, resp_sent} !== '0) begin
      miscompares++;
      $display("FAIL reset: cmd=%h rdy=%b ferr=%b trmt=%b tx_data=%h sent=%b required all 0",
               cmd, cmd_rdy, frame_err, trmt, tx_data, resp_sent);
    end
    rst_n = 1'b1;
    tick(2);
    vectors++;
    if ({cmd, cmd_rdy, frame_err, trmt, tx_data, resp_sent, cmd_l, cmd_rdy_l} !== '0) begin
      miscompares++; $display("FAIL post_reset: cmd=%h rdy=%b cmd_l=%h required 0", cmd, cmd_rdy, cmd_l);
    end
  endtask

  task automatic test_normal();
    int c0;
    c0 = clr_cnt_l;
    send_byte(1'b1, 8'h12, 1'b0);
    tick(3000);
    send_byte(1'b1, 8'h34, 1'b0);
    vectors++;
    if (cmd_l !== 16'h1234 || cmd_rdy_l !== 1'b1) begin
      miscompares++; $display("FAIL normal: cmd=%h rdy=%b required 1234/1", cmd_l, cmd_rdy_l);
    end
    tick(1);
    vectors++;
    if (clr_cnt_l - c0 != 2 || ferr_cnt_l != 0 || txl_cnt != 0 || tx_data_l !== 8'h00) begin
      miscompares++;
      $display("FAIL normal_pulses: clr %0d ferr %0d tx %0d required 2/0/0", clr_cnt_l - c0, ferr_cnt_l, txl_cnt);
    end
  endtask

  task automatic test_timeout();
    send_byte(1'b0, 8'hAB, 1'b0);
    tick(T);
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++; $display("FAIL timeout_early: frame_err=%b required 0 at cycle %0d", frame_err, T);
    end
    tick(1);
    vectors++;
    if (frame_err !== 1'b1 || cmd !== exp_cmd || cmd_rdy !== exp_rdy) begin
      miscompares++;
      $display("FAIL timeout: frame_err=%b cmd=%h required 1/%h at cycle %0d", frame_err, cmd, exp_cmd, T + 1);
    end
    tick(1);
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++; $display("FAIL timeout_pulse: frame_err=%b required 0", frame_err);
    end
    do_frame(8'h56, 8'h78, 7, 0);
  endtask

  task automatic test_overrun();
    do_frame(8'h01, 8'h02, 5, 1);
    do_frame(8'h03, 8'h04, 5, 0);
    do_frame(8'h05, 8'h06, 5, 2);
  endtask

  task automatic test_back_to_back();
    fork
      do_frame(8'($urandom), 8'($urandom), 4, 1);
      tx_once(8'($urandom), 3);
    join
  endtask

  task automatic test_random();
    int gap, sel;
    for (int i = 0; i < 25; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      gap = T;
      else if (sel == 1) gap = T + 1 + $urandom_range(0, 5);
      else               gap = $urandom_range(0, T - 1);
      do_frame(8'($urandom), 8'($urandom), gap, $urandom_range(0, 2));
    end
    for (int i = 0; i < 8; i++) tx_once(8'($urandom), $urandom_range(0, 6));
  endtask

  task automatic test_reset_mid();
    int f0, t0, s0;
    send_byte(1'b0, 8'($urandom), 1'b0);
    resp = 8'h3C; send_resp = 1'b1; tick(1); send_resp = 1'b0;
    tick(5);
    f0 = ferr_cnt; t0 = trmt_cnt; s0 = sent_cnt;
    tx_done = 1'b1;
    rst_n = 1'b0;
    tick(2);
    vectors++;
    if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || tx_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_mid: cmd=%h rdy=%b tx_data=%h required 0", cmd, cmd_rdy, tx_data);
    end
    tx_done = 1'b0; rst_n = 1'b1;
    exp_cmd = '0; exp_rdy = 1'b0;
    tick(T + 20);
    vectors++;
    if (ferr_cnt != f0 || trmt_cnt != t0 || sent_cnt != s0) begin
      miscompares++;
      $display("FAIL reset_pulses: ferr %0d trmt %0d sent %0d required 0", ferr_cnt - f0, trmt_cnt - t0, sent_cnt - s0);
    end
    do_frame(8'hCD, 8'hEF, 3, 0);
    vectors++;
    if (cmd !== 16'hCDEF || ferr_cnt != f0) begin
      miscompares++; $display("FAIL reset_recover: cmd=%h ferr %0d required CDEF/0", cmd, ferr_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    do_frame(8'h9A, 8'hBC, T, 1);
    test_overrun();
    tx_once(8'hA5, 4);
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Sequences the UART receive and transmit byte channels for the command interface. Drives the receiver's ready/clear handshake and assembles two received bytes, high byte first, into a 16-bit command. An inter-byte timeout discards partial frames. Also sequences single-byte responses into the UART transmitter, and sits between the UART pair and the command processor.

## Interface
- TIMEOUT_CYC, 65535: max clocks allowed between accepting the high byte and the low byte.
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- rx_rdy  input  1  receiver has a byte; level, held until cleared.
- rx_data  input  8  received byte; valid while rx_rdy=1.
- rx_clr_rdy  output  1  one-cycle pulse; consumes the current byte.
- cmd  output  16  assembled command {high, low}.
- cmd_rdy  output  1  level; cmd valid.
- clr_cmd_rdy  input  1  command processor acknowledges cmd.
- frame_err  output  1  one-cycle pulse on timeout or overrun.
- send_resp  input  1  request to transmit resp.
- resp  input  8  response byte; sampled with send_resp.
- trmt  output  1  one-cycle pulse; starts the transmitter.
- tx_data  output  8  byte to the transmitter; held until the next accepted send_resp.
- tx_done  input  1  transmitter finished; the transmitter clears it on trmt.
- resp_sent  output  1  one-cycle pulse; response transmission complete.

## Operation
- Receive FSM states:
  - HIGH_WAIT (reset state). On rx_rdy=1: latch rx_data into high_byte, pulse rx_clr_rdy, load timer with TIMEOUT_CYC, go to LOW_WAIT.
  - LOW_WAIT, with rx_rdy=1: cmd <= {high_byte, rx_data}, set cmd_rdy, pulse rx_clr_rdy, go to HIGH_WAIT.
  - LOW_WAIT, with rx_rdy=0 and timer==0: discard high_byte, pulse frame_err, go to HIGH_WAIT.
  - LOW_WAIT, otherwise: timer decrements by 1.
- rx_clr_rdy is asserted only in the cycle a byte is accepted. There is exactly one pulse per byte.
- Timer width is $clog2(TIMEOUT_CYC+1). The timer does not count in HIGH_WAIT.
- rx_rdy=1 in the same cycle timer==0: the byte is accepted and no error is raised.
- cmd_rdy is cleared only by clr_cmd_rdy. It is set only on frame completion.
- If completion and clr_cmd_rdy occur in the same cycle, set wins: cmd_rdy=1.
- Overrun: a frame completes while cmd_rdy=1. cmd is overwritten, cmd_rdy stays 1, and frame_err pulses.
- Transmit FSM states:
  - TX_IDLE (reset state). On send_resp=1: tx_data <= resp, pulse trmt, go to TX_BUSY.
  - TX_BUSY. tx_done is sampled from the cycle after trmt onward. On tx_done=1: pulse resp_sent, go to TX_IDLE.
- send_resp while in TX_BUSY is ignored and dropped.
- The receive and transmit FSMs are independent and may be active in the same cycle.

## Timing
- Reset values:
  - rx_clr_rdy=0, cmd=16'h0000, cmd_rdy=0, frame_err=0.
  - trmt=0, tx_data=8'h00, resp_sent=0.
  - Both FSMs in their idle states; timer=0.
- Asserting rst_n mid-frame or mid-transmit aborts immediately. No pulse of any kind is emitted.
- rx_clr_rdy is combinational from state and rx_rdy, in the acceptance cycle. The receiver drops rdy at the following edge, so no byte is accepted twice.
- cmd and cmd_rdy are registered and visible 1 cycle after the low-byte acceptance cycle.
- Timeout: frame_err asserts TIMEOUT_CYC+1 cycles after the high-byte acceptance cycle.
- trmt and tx_data are registered and asserted 1 cycle after send_resp is sampled.
- resp_sent is registered and asserted 1 cycle after tx_done is sampled high.
- frame_err, trmt and resp_sent are registered one-cycle pulses.

## Structure
- Package uart_cmd_pkg holds the rx_state_t enum {HIGH_WAIT, LOW_WAIT} and the tx_state_t enum {TX_IDLE, TX_BUSY}. It also holds CMD_W=16.
- Sub-module uart_frame_timer: loadable down-counter with a zero flag, parameterised by TIMEOUT_CYC.
- The two FSMs live in the top module, each with its own state register.

## Test plan
- Normal frame: bytes 0x12 then 0x34, 3000 clocks apart.
  - Required: cmd=16'h1234 and cmd_rdy=1 one cycle after the second rx_clr_rdy.
  - Required: exactly two rx_clr_rdy pulses.
- Timeout (TIMEOUT_CYC=100): byte 0xAB, then nothing.
  - Required: frame_err pulses at cycle 101 and cmd is unchanged.
  - Follow with 0x56, 0x78. Required: cmd=16'h5678.
- Overrun and simultaneous clear: frame 0x0102 with no clr_cmd_rdy, then frame 0x0304.
  - Required: cmd=16'h0304, cmd_rdy=1, one frame_err pulse.
  - Repeat with clr_cmd_rdy coincident with completion. Required: cmd_rdy=1.
- Timeout boundary (TIMEOUT_CYC=100): low byte arrives exactly in the cycle timer==0.
  - Required: accepted, no frame_err.
- Transmit: send_resp with resp=8'hA5.
  - Required: trmt pulses one cycle later with tx_data=8'hA5.
  - A second send_resp during TX_BUSY is ignored, with no further trmt.
  - tx_done asserted. Required: resp_sent pulses next cycle.
- Reset mid-frame: rst_n low after the high byte, release, then send 0xCD, 0xEF.
  - Required: cmd=16'hCDEF, with no frame_err at any point.
